pixel_row_streamer: RTL and testbench
=====================================

# pixel_row_streamer

- Captures a full image frame on a start strobe and streams it out one row per transfer over a valid/ready handshake.
- Out_Row is registered and Out_Index tracks the row counter.
- Sits between the image input stage and the row-consuming datapath, which applies backpressure through Out_Ready.
- Replaces purely combinational row selection with a buffered, flow-controlled source; optional zero-row padding for convolution windows.

## Interface
- PIX_W, 10: bits per pixel
- COLS, 28: pixels per row
- ROWS, 28: rows per image
- SEL_W, 5: row counter / Out_Index width; 2^SEL_W ≥ ROWS (≥ ROWS+2 with padding)
- One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- Start  in  1  capture In_Image and begin streaming; honoured only in IDLE
- In_Image  in  PIX_W*COLS*ROWS  flat frame; row k = bits [PIX_W*COLS*(k+1)-1 : PIX_W*COLS*k]
- Out_Row  out  PIX_W*COLS  current row, registered
- Out_Index  out  SEL_W  index of the row on Out_Row
- Out_Valid  out  1  Out_Row/Out_Index valid
- Out_Ready  in  1  consumer accepts; transfer = Out_Valid & Out_Ready at a rising edge
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle pulse after the last transfer

## Operation
- States: IDLE, STREAM, DONE.
- IDLE:
  - Out_Valid=0.
  - On Start: latch In_Image into the internal frame buffer, load Out_Row with the first emitted row, set Out_Index=0, go to STREAM.
- STREAM:
  - Out_Valid=1.
  - On each transfer: load Out_Row with the next row, read from the buffer (never from In_Image), and increment Out_Index.
  - On the transfer of the last row (index NROWS-1): go to DONE.
- DONE:
  - Out_Valid=0, Done=1 for exactly one cycle, then go to IDLE.
- Row counts:
  - NROWS = ROWS by default.
  - NROWS = ROWS+2 with padding (see Configuration).
- Start in STREAM or DONE: ignored; the buffer and stream are unaffected.
- In_Image changes after capture: no effect on output.
- Stall (Out_Valid & !Out_Ready): Out_Row and Out_Index held bit-stable; no row skipped or repeated.
- No wrap-around: the counter never passes NROWS-1; a new frame requires a new Start.
- Reset values:
  - State = IDLE.
  - Out_Row = 0, Out_Index = 0, Out_Valid = 0, Busy = 0, Done = 0.
  - Buffer contents are unspecified and unobservable.
- Reset mid-stream: aborts immediately; the partial frame is discarded; the next Start restarts at index 0.
- Reset and Start in the same cycle: reset wins.

## Timing
- Start sampled at edge E0 in IDLE → Out_Valid=1 with row index 0 after E0 (one-cycle latency).
- Out_Ready held high: one transfer per cycle, zero bubbles; transfers at E1..E_NROWS.
- Last transfer at edge E_NROWS → DONE; Done=1 and Out_Valid=0 during the following cycle.
- The next edge returns to IDLE; the earliest accepted new Start is the edge after that.
- Back-to-back frame period: NROWS+2 cycles minimum.
- Out_Ready is combinationally unused for outputs; all outputs come from registers.

## Configuration
- PIXEL_ROW_PAD_EN defined:
  - NROWS = ROWS+2.
  - Index 0 emits an all-zero row, indices 1..ROWS emit image rows 0..ROWS-1, index ROWS+1 emits an all-zero row.
- PIXEL_ROW_PAD_EN undefined:
  - NROWS = ROWS; index k emits image row k.
  - No pad logic is present.

## Test plan
All cases use the defaults; every pixel of image row r holds value r+1.
- Reset, then Start with Out_Ready=1 constant → Out_Valid high for 28 consecutive cycles; Out_Index 0..27; all pixels of index k equal k+1; Done pulses once in the next cycle; Busy falls after Done.
- Out_Ready pattern 1,0,0,1,0,1… → Out_Row/Out_Index unchanged during every stalled cycle; exactly 28 transfers, in order, all values correct.
- Second Start with an all-0x3FF image asserted at index 5 → ignored; the stream finishes with the original values; In_Image changed mid-stream also has no effect.
- reset asserted after the transfer of index 10 → next cycle Out_Valid=0, Out_Row=0, Out_Index=0, Busy=0; a fresh Start restarts at index 0 with correct data.
- PIXEL_ROW_PAD_EN defined → 30 transfers; indices 0 and 29 are all-zero rows; index k (1..28) pixels equal k; Done follows index 29.
- Start pulsed every cycle with Out_Ready=1 → new frames begin exactly 30 cycles apart (NROWS+2), each with Out_Index starting at 0.

Source files
------------

// File: rtl/pixel_row_streamer_if.sv
// Row stream handshake: pixel_row_streamer drives row/index/valid (master),
// the row-consuming datapath returns ready (slave).
interface pixel_row_streamer_if #(
    parameter int PIX_W = 10,
    parameter int COLS  = 28,
    parameter int SEL_W = 5
);
    logic [PIX_W*COLS-1:0] row;
    logic [SEL_W-1:0]      index;
    logic                  valid;
    logic                  ready;

    modport master (output row, index, valid, input ready);
    modport slave  (input row, index, valid, output ready);
endinterface

// File: rtl/pixel_row_streamer.sv
// Captures a frame on start and streams it row by row over a valid/ready handshake.
// Define PIXEL_ROW_PAD_EN to frame the image with an all-zero row above and below.
module pixel_row_streamer #(
    parameter int PIX_W = 10,
    parameter int COLS  = 28,
    parameter int ROWS  = 28,
    parameter int SEL_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PIX_W*COLS*ROWS-1:0] in_image,
    pixel_row_streamer_if.master       out,
    output logic                       busy,
    output logic                       done
);
    localparam int ROW_W = PIX_W * COLS;
`ifdef PIXEL_ROW_PAD_EN
    localparam int NROWS = ROWS + 2;
`else
    localparam int NROWS = ROWS;
`endif
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load_first;
    logic             advance;
    logic [SEL_W-1:0] idx_next;
    logic [ROW_W-1:0] first_row;
    logic [ROW_W-1:0] next_row;
    logic [ROW_W-1:0] frame_buf [ROWS];

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        load_first = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_STREAM;
                    load_first = 1'b1;
                end
            end
            ST_STREAM: begin
                if (out.ready) begin
                    if (out.index == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign idx_next = out.index + SEL_W'(1);

    // Row selection: the first row comes straight from the frame being captured,
    // every later row from the buffer so in_image may change freely mid-stream.
    always_comb begin
        next_row = '0;
`ifdef PIXEL_ROW_PAD_EN
        first_row = '0;
        if (idx_next >= SEL_W'(1) && idx_next <= SEL_W'(ROWS)) begin
            next_row = frame_buf[idx_next - SEL_W'(1)];
        end
`else
        first_row = in_image[ROW_W-1:0];
        if (idx_next < SEL_W'(ROWS)) begin
            next_row = frame_buf[idx_next];
        end
`endif
    end

    // NOTE: the frame buffer is deliberately not reset; its contents are only read after a capture.
    always_ff @(posedge clk) begin
        if (load_first && !reset) begin
            for (int k = 0; k < ROWS; k++) begin
                frame_buf[k] <= in_image[k*ROW_W +: ROW_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out.row   <= '0;
            out.index <= '0;
        end else if (load_first) begin
            out.row   <= first_row;
            out.index <= '0;
        end else if (advance) begin
            out.row   <= next_row;
            out.index <= idx_next;
        end
    end

    assign out.valid = (state == ST_STREAM);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
endmodule

// File: tb/tb_pixel_row_streamer.sv
// Self-checking bench for pixel_row_streamer: directed frames with random data and
// backpressure, checked against a frame-level reference model.
module tb_pixel_row_streamer;
    localparam int PIX_W = 10;
    localparam int COLS  = 28;
    localparam int ROWS  = 28;
    localparam int SEL_W = 5;
    localparam int ROW_W = PIX_W * COLS;
`ifdef PIXEL_ROW_PAD_EN
    localparam int NROWS = ROWS + 2;
`else
    localparam int NROWS = ROWS;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [ROW_W*ROWS-1:0]  in_image;
    logic                   busy;
    logic                   done;

    pixel_row_streamer_if #(.PIX_W(PIX_W), .COLS(COLS), .SEL_W(SEL_W)) bus ();

    pixel_row_streamer #(
        .PIX_W(PIX_W),
        .COLS (COLS),
        .ROWS (ROWS),
        .SEL_W(SEL_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_image(in_image),
        .out     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ROW_W-1:0] model_img [ROWS];
    bit               rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic logic [ROW_W-1:0] exp_row(input int k);
`ifdef PIXEL_ROW_PAD_EN
        if (k == 0 || k == ROWS + 1) return '0;
        return model_img[k-1];
`else
        return model_img[k];
`endif
    endfunction

    // mode 0: every pixel of row r is r+1; mode 1: random pixels; mode 2: all ones
    function automatic logic [ROW_W*ROWS-1:0] make_image(input int mode);
        logic [ROW_W*ROWS-1:0] img;
        logic [PIX_W-1:0]      pix;
        img = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (mode == 0)      pix = PIX_W'(r + 1);
                else if (mode == 1) pix = PIX_W'($urandom_range(0, (1 << PIX_W) - 1));
                else                pix = '1;
                img[(r*COLS + c)*PIX_W +: PIX_W] = pix;
            end
        end
        return img;
    endfunction

    task automatic chk_int(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ready_mode: 0 always ready, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
    // glitch_idx: at that index pulse start with an all-ones frame and leave in_image changed.
    // reset_after: reset right after the transfer of that index, then return.
    task automatic run_frame(input int img_mode, input int ready_mode,
                             input int glitch_idx, input int reset_after);
        logic [ROW_W*ROWS-1:0] img;
        int  xfers;
        int  cycles;
        bit  rdy;
        bit  glitched;
        img = make_image(img_mode);
        for (int r = 0; r < ROWS; r++) model_img[r] = img[r*ROW_W +: ROW_W];
        in_image = img;
        start    = 1'b1;
        bus.ready = 1'b0;
        step();
        start    = 1'b0;
        chk_int("start_busy", 32'(busy), 32'd1);
        xfers    = 0;
        cycles   = 0;
        glitched = 1'b0;
        while (xfers < NROWS) begin
            if (cycles > 2000) begin
                chk_int("stream_timeout", 32'(xfers), 32'(NROWS));
                break;
            end
            chk_int("valid", 32'(bus.valid), 32'd1);
            chk_int("done_low", 32'(done), 32'd0);
            chk_int("index", 32'(bus.index), 32'(xfers));
            chk_row("row", bus.row, exp_row(xfers));
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = rdy_pat[cycles % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (xfers == glitch_idx && !glitched) begin
                in_image = make_image(2);
                start    = 1'b1;
                glitched = 1'b1;
            end
            bus.ready = rdy;
            step();
            start = 1'b0;
            cycles++;
            if (rdy) begin
                if (xfers == reset_after) begin
                    reset     = 1'b1;
                    bus.ready = 1'b0;
                    step();
                    reset = 1'b0;
                    chk_int("rst_valid", 32'(bus.valid), 32'd0);
                    chk_int("rst_index", 32'(bus.index), 32'd0);
                    chk_row("rst_row", bus.row, '0);
                    chk_int("rst_busy", 32'(busy), 32'd0);
                    chk_int("rst_done", 32'(done), 32'd0);
                    return;
                end
                xfers++;
            end
        end
        bus.ready = 1'b0;
        chk_int("end_valid", 32'(bus.valid), 32'd0);
        chk_int("end_done", 32'(done), 32'd1);
        chk_int("end_busy", 32'(busy), 32'd1);
        step();
        chk_int("idle_done", 32'(done), 32'd0);
        chk_int("idle_busy", 32'(busy), 32'd0);
        chk_int("idle_valid", 32'(bus.valid), 32'd0);
    endtask

    initial begin
        int starts[$];
        bit prev_valid;
        int waited;

        reset     = 1'b1;
        start     = 1'b0;
        bus.ready = 1'b0;
        in_image  = '0;
        step();
        step();
        reset = 1'b0;
        chk_int("reset_valid", 32'(bus.valid), 32'd0);
        chk_int("reset_index", 32'(bus.index), 32'd0);
        chk_row("reset_row", bus.row, '0);
        chk_int("reset_busy", 32'(busy), 32'd0);
        chk_int("reset_done", 32'(done), 32'd0);

        // reset and start together: reset wins
        in_image = make_image(0);
        reset    = 1'b1;
        start    = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk_int("rst_start_valid", 32'(bus.valid), 32'd0);
        chk_int("rst_start_busy", 32'(busy), 32'd0);
        step();
        chk_int("rst_start_idle", 32'(busy), 32'd0);

        run_frame(0, 0, -1, -1);
        run_frame(0, 1, -1, -1);
        run_frame(0, 0, 5, -1);
        run_frame(0, 0, -1, 10);
        run_frame(0, 0, -1, -1);
        run_frame(1, 2, 7, -1);
        for (int i = 0; i < 3; i++) run_frame(1, 2, -1, -1);
        run_frame(1, 1, 0, -1);

        // start held every cycle with ready high: frames NROWS+2 cycles apart
        in_image   = make_image(0);
        start      = 1'b1;
        bus.ready  = 1'b1;
        prev_valid = 1'b0;
        for (int cyc = 0; cyc < 3*(NROWS + 2) + 5; cyc++) begin
            step();
            if (bus.valid && !prev_valid) begin
                starts.push_back(cyc);
                chk_int("b2b_first_index", 32'(bus.index), 32'd0);
            end
            prev_valid = bus.valid;
        end
        start = 1'b0;
        chk_int("b2b_frame_count", 32'(starts.size() >= 3), 32'd1);
        if (starts.size() >= 3) begin
            chk_int("b2b_period_a", 32'(starts[1] - starts[0]), 32'(NROWS + 2));
            chk_int("b2b_period_b", 32'(starts[2] - starts[1]), 32'(NROWS + 2));
        end
        waited = 0;
        while (busy && waited < 200) begin
            step();
            waited++;
        end
        chk_int("b2b_drain_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
